// File: rtl/muldiv_iter.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, behind a valid/ready handshake.
module muldiv_iter #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      op_reg, op_next;
  logic [XLEN-1:0] hi_reg, hi_next;
  logic [XLEN-1:0] lo_reg, lo_next;
  logic [XLEN-1:0] opnd_reg, opnd_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;

  // Request decode: signedness, magnitudes and early-out detection
  logic            a_signed, b_signed, a_neg, b_neg, b_zero, sdiv_ovf, early;
  logic [XLEN-1:0] a_mag, b_mag, early_res;

  always_comb begin
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg     = a_signed && a[XLEN-1];
    b_neg     = b_signed && b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
    sdiv_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) && (a == MIN_INT) && (b == '1);
    early     = EARLY_OUT && funct3[2] && (b_zero || sdiv_ovf);
    early_res = '0;
    if (funct3[1]) early_res = b_zero ? a : '0;
    else           early_res = b_zero ? '1 : MIN_INT;
  end

  // One iteration step; hi holds partial product / partial remainder,
  // lo holds the multiplier / dividend being shifted out and result bits shifted in
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   iter_hi, iter_lo, quo, rem;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ok    = !div_diff[XLEN];
    if (op_reg[2]) begin
      iter_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      iter_lo = {lo_reg[XLEN-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
    prod     = {iter_hi, iter_lo};
    prod_fix = neg_q_reg ? -prod : prod;
    quo      = neg_q_reg ? -iter_lo : iter_lo;
    rem      = neg_r_reg ? -iter_hi : iter_hi;
    case (op_reg)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    opnd_next   = opnd_reg;
    result_next = result_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next    = funct3;
            hi_next    = '0;
            lo_next    = funct3[2] ? a_mag : b_mag;
            opnd_next  = funct3[2] ? b_mag : a_mag;
            // Quotient of a divide by zero stays all ones, so never negate it
            neg_q_next = (a_neg ^ b_neg) && !(funct3[2] && b_zero);
            neg_r_next = a_neg;
            if (early) begin
              result_next = early_res;
              cnt_next    = '0;
              state_next  = DONE;
            end else begin
              cnt_next   = CW'(XLEN);
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          hi_next  = iter_hi;
          lo_next  = iter_lo;
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            result_next = fin_res;
            state_next  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opnd_reg   <= opnd_next;
      result_reg <= result_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
    end
  end

  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed cases on a 32-bit early-out unit, random ops on
// both a 32-bit and a 64-bit always-iterate unit against an arithmetic reference.
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b0;
  logic [2:0]  f32 = '0;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic        iv64 = 1'b0, ir64, ov64, ordy64 = 1'b0;
  logic [2:0]  f64 = '0;
  logic [63:0] a64 = '0, b64 = '0, r64;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .funct3(f32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(ordy32), .result(r32)
  );

  muldiv_iter #(.XLEN(64), .EARLY_OUT(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .funct3(f64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(ordy64), .result(r64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics with wide signed/unsigned arithmetic
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] f,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, minv, r;
    logic signed [129:0] sa, sb, za, zb, p;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua   = a & mask;
    ub   = b & mask;
    minv = 64'd1 << (w - 1);
    za   = $signed({66'd0, ua});
    zb   = $signed({66'd0, ub});
    sa   = ua[w-1] ? za - (130'sd1 <<< w) : za;
    sb   = ub[w-1] ? zb - (130'sd1 <<< w) : zb;
    r    = '0;
    case (f)
      3'd0: begin p = za * zb; r = p[63:0]; end
      3'd1: begin p = sa * sb; p = p >>> w; r = p[63:0]; end
      3'd2: begin p = sa * zb; p = p >>> w; r = p[63:0]; end
      3'd3: begin p = za * zb; p = p >>> w; r = p[63:0]; end
      3'd4: begin
        if (ub == 0) r = '1;
        else if (ua == minv && ub == mask) r = minv;
        else begin p = sa / sb; r = p[63:0]; end
      end
      3'd5: begin
        if (ub == 0) r = '1;
        else begin p = za / zb; r = p[63:0]; end
      end
      3'd6: begin
        if (ub == 0) r = ua;
        else if (ua == minv && ub == mask) r = '0;
        else begin p = sa % sb; r = p[63:0]; end
      end
      default: begin
        if (ub == 0) r = ua;
        else begin p = za % zb; r = p[63:0]; end
      end
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] rnd_val(input int w);
    logic [63:0] v, mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  // Issue one op, wait for the result, take it and check the handshake afterwards
  task automatic do_op(input bit wide, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                       input string tag);
    int lat;
    logic [63:0] res;
    check({tag, "/in_ready"}, wide ? ir64 : ir32, 64'd1);
    if (wide) begin iv64 = 1'b1; f64 = f; a64 = a; b64 = b; end
    else begin iv32 = 1'b1; f32 = f; a32 = a[31:0]; b32 = b[31:0]; end
    @(negedge clk);
    iv32 = 1'b0; iv64 = 1'b0;
    f32 = 3'($urandom); f64 = 3'($urandom);
    a32 = $urandom; b32 = $urandom;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = 0;
    while (!(wide ? ov64 : ov32) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    res = wide ? r64 : {32'd0, r32};
    check({tag, "/result"}, res, exp);
    if (wide) ordy64 = 1'b1; else ordy32 = 1'b1;
    @(negedge clk);
    ordy32 = 1'b0; ordy64 = 1'b0;
    check({tag, "/out_valid_after_take"}, wide ? ov64 : ov32, 64'd0);
    check({tag, "/in_ready_after_take"}, wide ? ir64 : ir32, 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb, rexp;
    logic [2:0]  rf;
    bit          seen;
    int          elat;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/in_ready32", ir32, 64'd0);
    check("rst/out_valid32", ov32, 64'd0);
    check("rst/result32", r32, 64'd0);
    check("rst/in_ready64", ir64, 64'd0);
    check("rst/result64", r64, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic, 32-bit with early-out
    do_op(0, 3'b000, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 32, "MUL 7*-3");
    do_op(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 32, "MULHU");
    do_op(0, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 32, "MULH min*min");
    do_op(0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32, "MULHSU");
    do_op(0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 32, "DIV -7/2");
    do_op(0, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 32, "REM -7%2");
    do_op(0, 3'b101, 64'hFFFF_FFF9, 64'd2, 64'h7FFF_FFFC, 32, "DIVU");
    do_op(0, 3'b111, 64'hFFFF_FFF9, 64'd2, 64'd1, 32, "REMU");
    do_op(0, 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF, 0, "DIV 5/0");
    do_op(0, 3'b110, 64'd5, 64'd0, 64'd5, 0, "REM 5%0");
    do_op(0, 3'b111, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFF9, 0, "REMU x%0");
    do_op(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0, "DIV min/-1");
    do_op(0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0, "REM min/-1");

    // Consumer stall in DONE; a request offered meanwhile must be ignored
    iv32 = 1'b1; f32 = 3'b000; a32 = 32'd3; b32 = 32'd5;
    @(negedge clk);
    iv32 = 1'b0;
    elat = 0;
    while (!ov32 && elat < 100) begin @(negedge clk); elat++; end
    check("stall/latency", 64'(elat), 64'd32);
    for (int i = 0; i < 5; i++) begin
      iv32 = 1'b1; f32 = 3'b101; a32 = 32'd99; b32 = 32'd9;
      @(negedge clk);
      check("stall/out_valid", ov32, 64'd1);
      check("stall/result", r32, 64'd15);
      check("stall/in_ready", ir32, 64'd0);
    end
    iv32 = 1'b0; ordy32 = 1'b1;
    @(negedge clk);
    ordy32 = 1'b0;
    check("stall/out_valid_after_take", ov32, 64'd0);
    check("stall/in_ready_after_take", ir32, 64'd1);

    // Flush in the 10th BUSY cycle, with in_valid held high on the flush edge
    iv32 = 1'b1; f32 = 3'b101; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; iv32 = 1'b1; f32 = 3'b000; a32 = 32'd2; b32 = 32'd2;
    @(negedge clk);
    flush = 1'b0; iv32 = 1'b0;
    check("flush/out_valid", ov32, 64'd0);
    check("flush/in_ready", ir32, 64'd1);
    check("flush/result_kept", r32, 64'd15);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ov32) seen = 1'b1; end
    check("flush/no_late_result", 64'(seen), 64'd0);
    do_op(0, 3'b101, 64'd100, 64'd7, 64'd14, 32, "DIVU 100/7");

    // Reset in the middle of a divide
    iv32 = 1'b1; f32 = 3'b100; a32 = 32'hFFFF_FF9C; b32 = 32'd7;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst/out_valid", ov32, 64'd0);
    check("midrst/result", r32, 64'd0);
    check("midrst/in_ready", ir32, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst/in_ready_after", ir32, 64'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ov32) seen = 1'b1; end
    check("midrst/no_late_result", 64'(seen), 64'd0);

    // 64-bit, no early-out: special divide cases still iterate fully
    do_op(1, 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64, "DIV64 5/0");
    do_op(1, 3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64, "REM64 -5%0");
    do_op(1, 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64, "DIV64 min/-1");
    do_op(1, 3'b110, 64'h8000_0000_0000_0000, '1, 64'd0, 64, "REM64 min/-1");

    // Random ops against the reference
    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom);
      ra = rnd_val(32);
      rb = rnd_val(32);
      rexp = ref_op(32, rf, ra, rb);
      elat = (rf[2] && (rb == 0 || (!rf[0] && ra == 64'h8000_0000 && rb == 64'hFFFF_FFFF))) ? 0 : 32;
      do_op(0, rf, ra, rb, rexp, elat, $sformatf("rnd32 f=%0d a=%h b=%h", rf, ra, rb));
    end
    for (int i = 0; i < 300; i++) begin
      rf = 3'($urandom);
      ra = rnd_val(64);
      rb = rnd_val(64);
      rexp = ref_op(64, rf, ra, rb);
      do_op(1, rf, ra, rb, rexp, 64, $sformatf("rnd64 f=%0d a=%h b=%h", rf, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
